// File: rtl/mem_axi_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_axi_arb_if
// Description : Bus bundle for mem_axi_arb: per-port AXI-style request/data
//               channels plus the single downstream memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_axi_arb_if #(
    parameter int NUM_PORTS = 2,
    parameter int LEN_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64
);
    localparam int STRB_BITS = DATA_BITS / 8;

    logic [NUM_PORTS-1:0]           s_awvalid;
    logic [NUM_PORTS-1:0]           s_arvalid;
    logic [NUM_PORTS-1:0]           s_awready;
    logic [NUM_PORTS-1:0]           s_arready;
    logic [NUM_PORTS*ADDR_BITS-1:0] s_awaddr;
    logic [NUM_PORTS*ADDR_BITS-1:0] s_araddr;
    logic [NUM_PORTS*LEN_BITS-1:0]  s_awlen;
    logic [NUM_PORTS*LEN_BITS-1:0]  s_arlen;
    logic [NUM_PORTS-1:0]           s_wvalid;
    logic [NUM_PORTS-1:0]           s_wlast;
    logic [NUM_PORTS-1:0]           s_wready;
    logic [NUM_PORTS*DATA_BITS-1:0] s_wdata;
    logic [NUM_PORTS*STRB_BITS-1:0] s_wstrb;
    logic [NUM_PORTS-1:0]           s_rvalid;
    logic [NUM_PORTS-1:0]           s_rlast;
    logic [DATA_BITS-1:0]           s_rdata;
    logic [NUM_PORTS-1:0]           s_rready;
    logic [NUM_PORTS-1:0]           s_bready;
    logic [NUM_PORTS-1:0]           s_bvalid;
    logic [1:0]                     s_bresp;

    logic                           mem_req_valid;
    logic                           mem_req_opcode;
    logic [LEN_BITS-1:0]            mem_req_len;
    logic [ADDR_BITS-1:0]           mem_req_addr;
    logic                           mem_wr_valid;
    logic [DATA_BITS-1:0]           mem_wr_bits;
    logic [STRB_BITS-1:0]           mem_wr_strb;
    logic                           mem_rd_valid;
    logic [DATA_BITS-1:0]           mem_rd_bits;
    logic                           mem_rd_ready;

    logic                           timeout_err;

    // Arbiter's view: AXI masters drive the s_* requests, memory drives rd beats.
    modport slave (
        input  s_awvalid, s_arvalid, s_awaddr, s_araddr, s_awlen, s_arlen,
        input  s_wvalid, s_wlast, s_wdata, s_wstrb, s_rready, s_bready,
        output s_awready, s_arready, s_wready, s_rvalid, s_rlast, s_rdata,
        output s_bvalid, s_bresp,
        output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        output mem_wr_valid, mem_wr_bits, mem_wr_strb, mem_rd_ready,
        input  mem_rd_valid, mem_rd_bits,
        output timeout_err
    );

    modport master (
        output s_awvalid, s_arvalid, s_awaddr, s_araddr, s_awlen, s_arlen,
        output s_wvalid, s_wlast, s_wdata, s_wstrb, s_rready, s_bready,
        input  s_awready, s_arready, s_wready, s_rvalid, s_rlast, s_rdata,
        input  s_bvalid, s_bresp,
        input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
        input  mem_wr_valid, mem_wr_bits, mem_wr_strb, mem_rd_ready,
        output mem_rd_valid, mem_rd_bits,
        input  timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_axi_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_axi_arb
// Description : Round-robin arbiter of NUM_PORTS AXI-style masters onto one
//               burst memory port, with write-data idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_axi_arb #(
    parameter int NUM_PORTS = 2,
    parameter int LEN_BITS  = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clock,
    input  logic         reset,
    mem_axi_arb_if.slave bus
);
    localparam int                 STRB_BITS   = DATA_BITS / 8;
    localparam int                 c_idx_w     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [31:0]        c_timeout   = 32'(TIMEOUT);
    localparam logic [c_idx_w-1:0] c_last_port = c_idx_w'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_DATA  = 2'd1,
        ST_WRITE_DATA = 2'd2,
        ST_WRITE_ACK  = 2'd3
    } state_t;

    state_t               r_state_q,   w_state_d;
    logic [c_idx_w-1:0]   r_gnt_q,     w_gnt_d;
    logic [c_idx_w-1:0]   r_rr_q,      w_rr_d;
    logic [LEN_BITS-1:0]  r_cnt_q,     w_cnt_d;
    logic [31:0]          r_idle_q,    w_idle_d;
    logic [1:0]           r_bresp_q,   w_bresp_d;
    logic                 r_timeout_q, w_timeout_d;

    logic [NUM_PORTS-1:0] w_req;
    logic [c_idx_w-1:0]   w_sel;
    logic [c_idx_w-1:0]   w_idx;
    logic                 w_found;
    int                   w_sum;

    // Rotating search: first requester at or after the round-robin pointer.
    always_comb begin
        w_req   = bus.s_arvalid | bus.s_awvalid;
        w_sel   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_sum   = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = int'(r_rr_q) + k;
            if (w_sum >= NUM_PORTS) begin
                w_sum = w_sum - NUM_PORTS;
            end
            w_idx = c_idx_w'(w_sum);
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_gnt_d     = r_gnt_q;
        w_rr_d      = r_rr_q;
        w_cnt_d     = r_cnt_q;
        w_idle_d    = r_idle_q;
        w_bresp_d   = r_bresp_q;
        w_timeout_d = 1'b0;

        bus.s_arready      = '0;
        bus.s_awready      = '0;
        bus.s_wready       = '0;
        bus.s_rvalid       = '0;
        bus.s_rlast        = '0;
        bus.s_bvalid       = '0;
        bus.s_rdata        = bus.mem_rd_bits;
        bus.s_bresp        = r_bresp_q;
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_opcode = 1'b0;
        bus.mem_req_len    = '0;
        bus.mem_req_addr   = '0;
        bus.mem_wr_valid   = 1'b0;
        bus.mem_wr_bits    = '0;
        bus.mem_wr_strb    = '0;
        bus.mem_rd_ready   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                w_idle_d = '0;
                if (w_found) begin
                    w_gnt_d           = w_sel;
                    w_rr_d            = (w_sel == c_last_port) ? '0 : w_sel + 1'b1;
                    bus.mem_req_valid = 1'b1;
                    if (bus.s_arvalid[w_sel]) begin
                        bus.s_arready[w_sel] = 1'b1;
                        bus.mem_req_opcode   = 1'b0;
                        bus.mem_req_addr     = bus.s_araddr[w_sel*ADDR_BITS +: ADDR_BITS];
                        bus.mem_req_len      = bus.s_arlen[w_sel*LEN_BITS +: LEN_BITS];
                        w_cnt_d              = bus.s_arlen[w_sel*LEN_BITS +: LEN_BITS];
                        w_state_d            = ST_READ_DATA;
                    end else begin
                        bus.s_awready[w_sel] = 1'b1;
                        bus.mem_req_opcode   = 1'b1;
                        bus.mem_req_addr     = bus.s_awaddr[w_sel*ADDR_BITS +: ADDR_BITS];
                        bus.mem_req_len      = bus.s_awlen[w_sel*LEN_BITS +: LEN_BITS];
                        w_cnt_d              = bus.s_awlen[w_sel*LEN_BITS +: LEN_BITS];
                        w_state_d            = ST_WRITE_DATA;
                    end
                end
            end

            ST_READ_DATA: begin
                bus.s_rvalid[r_gnt_q] = bus.mem_rd_valid;
                bus.s_rlast[r_gnt_q]  = (r_cnt_q == '0);
                bus.mem_rd_ready      = bus.s_rready[r_gnt_q];
                if (bus.mem_rd_valid && bus.s_rready[r_gnt_q]) begin
                    if (r_cnt_q == '0) begin
                        w_state_d = ST_IDLE;
                    end else begin
                        w_cnt_d = r_cnt_q - 1'b1;
                    end
                end
            end

            ST_WRITE_DATA: begin
                bus.s_wready[r_gnt_q] = 1'b1;
                bus.mem_wr_valid      = bus.s_wvalid[r_gnt_q];
                bus.mem_wr_bits       = bus.s_wdata[r_gnt_q*DATA_BITS +: DATA_BITS];
                bus.mem_wr_strb       = bus.s_wstrb[r_gnt_q*STRB_BITS +: STRB_BITS];
                if (bus.s_wvalid[r_gnt_q]) begin
                    w_idle_d = '0;
                    // Burst ends on whichever comes first; a mismatch is flagged SLVERR.
                    if (bus.s_wlast[r_gnt_q] || (r_cnt_q == '0)) begin
                        w_bresp_d = (bus.s_wlast[r_gnt_q] && (r_cnt_q == '0)) ? 2'b00 : 2'b10;
                        w_state_d = ST_WRITE_ACK;
                    end else begin
                        w_cnt_d = r_cnt_q - 1'b1;
                    end
                end else if ((r_idle_q + 32'd1) >= c_timeout) begin
                    w_idle_d    = '0;
                    w_timeout_d = 1'b1;
                    w_state_d   = ST_IDLE;
                end else begin
                    w_idle_d = r_idle_q + 32'd1;
                end
            end

            ST_WRITE_ACK: begin
                bus.s_bvalid[r_gnt_q] = 1'b1;
                if (bus.s_bready[r_gnt_q]) begin
                    w_state_d = ST_IDLE;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q   <= ST_IDLE;
            r_gnt_q     <= '0;
            r_rr_q      <= '0;
            r_cnt_q     <= '0;
            r_idle_q    <= '0;
            r_bresp_q   <= 2'b00;
            r_timeout_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_gnt_q     <= w_gnt_d;
            r_rr_q      <= w_rr_d;
            r_cnt_q     <= w_cnt_d;
            r_idle_q    <= w_idle_d;
            r_bresp_q   <= w_bresp_d;
            r_timeout_q <= w_timeout_d;
        end
    end

    assign bus.timeout_err = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_axi_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_axi_arb
// Description : Directed + randomized self-checking bench for mem_axi_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_axi_arb;
    localparam int NP = 2;
    localparam int LB = 8;
    localparam int AB = 32;
    localparam int DB = 64;
    localparam int SB = DB / 8;
    localparam int TO = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   m_rr = 0;

    logic [AB-1:0] t_araddr [NP];
    logic [AB-1:0] t_awaddr [NP];
    int            t_arlen  [NP];
    int            t_awlen  [NP];

    mem_axi_arb_if #(.NUM_PORTS(NP), .LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    mem_axi_arb #(
        .NUM_PORTS(NP), .LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NP-1:0] req, input int rr);
        for (int k = 0; k < NP; k++) begin
            if (req[(rr + k) % NP]) return (rr + k) % NP;
        end
        return 0;
    endfunction

    task automatic clear_inputs();
        bus.s_awvalid = '0; bus.s_arvalid = '0;
        bus.s_awaddr  = '0; bus.s_araddr  = '0;
        bus.s_awlen   = '0; bus.s_arlen   = '0;
        bus.s_wvalid  = '0; bus.s_wlast   = '0;
        bus.s_wdata   = '0; bus.s_wstrb   = '0;
        bus.s_rready  = '0; bus.s_bready  = '0;
        bus.mem_rd_valid = 1'b0; bus.mem_rd_bits = '0;
    endtask

    task automatic set_port(input int p, input bit rd, input logic [AB-1:0] a, input int len);
        if (rd) begin
            bus.s_arvalid[p] = 1'b1;
            bus.s_araddr[p*AB +: AB] = a;
            bus.s_arlen[p*LB +: LB]  = LB'(len);
            t_araddr[p] = a; t_arlen[p] = len;
        end else begin
            bus.s_awvalid[p] = 1'b1;
            bus.s_awaddr[p*AB +: AB] = a;
            bus.s_awlen[p*LB +: LB]  = LB'(len);
            t_awaddr[p] = a; t_awlen[p] = len;
        end
    endtask

    // Grant expected from the round-robin rule: first requester at/after m_rr, read wins.
    task automatic arbitrate(output int g, output bit rd, output int len, input bit keep);
        logic [NP-1:0] req;
        req = bus.s_arvalid | bus.s_awvalid;
        g   = pick(req, m_rr);
        rd  = bus.s_arvalid[g];
        len = rd ? t_arlen[g] : t_awlen[g];
        @(negedge clock);
        chk("arready", 64'(bus.s_arready), rd ? (64'(1) << g) : 64'(0));
        chk("awready", 64'(bus.s_awready), rd ? 64'(0) : (64'(1) << g));
        chk("req_valid", 64'(bus.mem_req_valid), 64'(1));
        chk("req_opcode", 64'(bus.mem_req_opcode), rd ? 64'(0) : 64'(1));
        chk("req_addr", 64'(bus.mem_req_addr), 64'(rd ? t_araddr[g] : t_awaddr[g]));
        chk("req_len", 64'(bus.mem_req_len), 64'(len));
        m_rr = (g + 1) % NP;
        @(posedge clock); #1;
        if (!keep) begin
            bus.s_arvalid = '0;
            bus.s_awvalid = '0;
        end
    endtask

    task automatic read_data(input int g, input int len);
        int b;
        int guard;
        logic [DB-1:0] d;
        b = 0; guard = 0;
        while (b <= len && guard < 200) begin
            guard++;
            d = {$urandom, $urandom};
            bus.mem_rd_valid = ($urandom_range(0, 3) != 0);
            bus.mem_rd_bits  = d;
            bus.s_rready     = NP'($urandom);
            bus.s_rready[g]  = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            chk("rvalid", 64'(bus.s_rvalid), bus.mem_rd_valid ? (64'(1) << g) : 64'(0));
            chk("rd_ready", 64'(bus.mem_rd_ready), 64'(bus.s_rready[g]));
            chk("arready_busy", 64'(bus.s_arready), 64'(0));
            if (bus.mem_rd_valid) begin
                chk("rdata", 64'(bus.s_rdata), 64'(d));
                chk("rlast", 64'(bus.s_rlast), (b == len) ? (64'(1) << g) : 64'(0));
            end
            @(posedge clock); #1;
            if (bus.mem_rd_valid && bus.s_rready[g]) b++;
        end
        chk("r_beats", 64'(b), 64'(len + 1));
        bus.mem_rd_valid = 1'b0;
        bus.s_rready     = '0;
    endtask

    // Burst ends at min(len, wlast_at)+1 beats; OKAY only when wlast lands on the final beat.
    task automatic write_data(input int g, input int len, input int wlast_at, input int strb_fix);
        int nb;
        int b;
        int guard;
        int hold;
        logic [1:0]    resp;
        logic [DB-1:0] d;
        logic [SB-1:0] s;
        nb   = ((wlast_at < len) ? wlast_at : len) + 1;
        resp = (wlast_at == len) ? 2'b00 : 2'b10;
        b = 0; guard = 0;
        while (b < nb && guard < 200) begin
            guard++;
            d = {$urandom, $urandom};
            s = (strb_fix < 0) ? SB'($urandom) : SB'(strb_fix);
            for (int q = 0; q < NP; q++) begin
                bus.s_wdata[q*DB +: DB] = {$urandom, $urandom};
                bus.s_wstrb[q*SB +: SB] = SB'($urandom);
            end
            bus.s_wdata[g*DB +: DB] = d;
            bus.s_wstrb[g*SB +: SB] = s;
            bus.s_wvalid    = '0;
            bus.s_wvalid[g] = ($urandom_range(0, 3) != 0);
            bus.s_wlast     = '0;
            bus.s_wlast[g]  = (b == wlast_at);
            @(negedge clock);
            chk("wready", 64'(bus.s_wready), 64'(1) << g);
            chk("wr_valid", 64'(bus.mem_wr_valid), 64'(bus.s_wvalid[g]));
            if (bus.s_wvalid[g]) begin
                chk("wr_bits", 64'(bus.mem_wr_bits), 64'(d));
                chk("wr_strb", 64'(bus.mem_wr_strb), 64'(s));
            end
            @(posedge clock); #1;
            if (bus.s_wvalid[g]) b++;
        end
        chk("w_beats", 64'(b), 64'(nb));
        bus.s_wlast = '0;
        hold = $urandom_range(1, 3);
        for (int k = 0; k <= hold; k++) begin
            bus.s_wvalid    = '0;
            bus.s_wvalid[g] = 1'b1;
            bus.s_bready    = '0;
            bus.s_bready[g] = (k == hold);
            @(negedge clock);
            chk("bvalid", 64'(bus.s_bvalid), 64'(1) << g);
            chk("bresp", 64'(bus.s_bresp), 64'(resp));
            chk("wr_valid_ack", 64'(bus.mem_wr_valid), 64'(0));
            chk("wready_ack", 64'(bus.s_wready), 64'(0));
            @(posedge clock); #1;
        end
        bus.s_wvalid = '0;
        bus.s_bready = '0;
        @(negedge clock);
        chk("bvalid_done", 64'(bus.s_bvalid), 64'(0));
        @(posedge clock); #1;
    endtask

    initial begin : main
        int  g;
        bit  rd;
        int  len;
        int  wr_cycles;
        int  pulses;
        int  bv;
        logic [NP-1:0] arv;
        logic [NP-1:0] awv;

        clear_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_arready", 64'(bus.s_arready), 64'(0));
        chk("rst_awready", 64'(bus.s_awready), 64'(0));
        chk("rst_rvalid", 64'(bus.s_rvalid), 64'(0));
        chk("rst_wready", 64'(bus.s_wready), 64'(0));
        chk("rst_bvalid", 64'(bus.s_bvalid), 64'(0));
        chk("rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
        chk("rst_wr_valid", 64'(bus.mem_wr_valid), 64'(0));
        chk("rst_rd_ready", 64'(bus.mem_rd_ready), 64'(0));
        chk("rst_timeout", 64'(bus.timeout_err), 64'(0));
        @(posedge clock); #1;

        // Both ports hold ARVALID: grants must alternate.
        set_port(0, 1'b1, $urandom, 0);
        set_port(1, 1'b1, $urandom, 0);
        for (int k = 0; k < 4; k++) begin
            arbitrate(g, rd, len, 1'b1);
            read_data(g, len);
        end
        clear_inputs();

        set_port(0, 1'b1, 32'h100, 3);
        arbitrate(g, rd, len, 1'b0);
        read_data(g, len);

        set_port(1, 1'b0, $urandom, 1);
        arbitrate(g, rd, len, 1'b0);
        write_data(g, len, 1, 8'h0F);

        set_port(0, 1'b0, $urandom, 3);
        arbitrate(g, rd, len, 1'b0);
        write_data(g, len, 1, -1);

        set_port(1, 1'b0, $urandom, 1);
        arbitrate(g, rd, len, 1'b0);
        write_data(g, len, 5, -1);

        set_port(0, 1'b1, $urandom, 2);
        set_port(0, 1'b0, $urandom, 1);
        arbitrate(g, rd, len, 1'b0);
        if (rd) read_data(g, len); else write_data(g, len, len, -1);

        // Write abandoned after TO idle data cycles.
        set_port(0, 1'b0, $urandom, 2);
        arbitrate(g, rd, len, 1'b0);
        wr_cycles = 0; pulses = 0; bv = 0;
        bus.s_bready = '1;
        for (int k = 0; k < TO + 8; k++) begin
            @(negedge clock);
            if (bus.s_wready[0]) wr_cycles++;
            if (bus.timeout_err) pulses++;
            if (bus.s_bvalid != '0) bv++;
            @(posedge clock); #1;
        end
        bus.s_bready = '0;
        chk("to_wready_cycles", 64'(wr_cycles), 64'(TO));
        chk("to_pulses", 64'(pulses), 64'(1));
        chk("to_no_bvalid", 64'(bv), 64'(0));

        for (int it = 0; it < 12; it++) begin
            arv = NP'($urandom);
            awv = NP'($urandom);
            if ((arv | awv) == '0) arv[0] = 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (arv[p]) set_port(p, 1'b1, $urandom, $urandom_range(0, 4));
                if (awv[p]) set_port(p, 1'b0, $urandom, $urandom_range(0, 4));
            end
            arbitrate(g, rd, len, 1'b0);
            if (rd) read_data(g, len);
            else write_data(g, len,
                            ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + 1) : len, -1);
        end

        // Reset in the middle of a 4-beat read on port 0.
        clear_inputs();
        set_port(0, 1'b1, $urandom, 3);
        arbitrate(g, rd, len, 1'b0);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_bits  = {$urandom, $urandom};
        bus.s_rready     = '1;
        @(negedge clock);
        chk("pre_rst_rvalid", 64'(bus.s_rvalid), 64'(1));
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_rr  = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("post_rst_rvalid", 64'(bus.s_rvalid), 64'(0));
            chk("post_rst_rd_ready", 64'(bus.mem_rd_ready), 64'(0));
            @(posedge clock); #1;
        end
        clear_inputs();
        set_port(0, 1'b1, $urandom, 0);
        set_port(1, 1'b1, $urandom, 0);
        arbitrate(g, rd, len, 1'b0);
        read_data(g, len);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
